pm32_arbiter: RTL and testbench
===============================

Name: pm32_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pm32 signed 32x32 serial multiplier between N requesters. It captures the winning requester's operands and holds them stable for the whole operation. It issues the single-cycle start, waits for completion and returns the 64-bit product tagged with the requester ID. A watchdog aborts any operation whose done never arrives.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must satisfy 2**IDW >= N
TIMEOUT, 100, max cycles in WAIT before abort (must exceed 66)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
req  in  N  per-requester request level; requester holds operands stable while req=1
mc_in  in  32*N  multiplicand bus; requester i at bits [32i+31:32i]
mp_in  in  32*N  multiplier bus, same packing
gnt  out  N  one-hot, one-cycle pulse: operands of that requester captured this cycle
rsp_valid  out  1  one-cycle pulse: result available
rsp_id  out  IDW  index of requester owning rsp_p
rsp_p  out  64  signed product (0 on error)
rsp_err  out  1  valid with rsp_valid: operation timed out
busy  out  1  high whenever state != IDLE
mul_start  out  1  to pm32 start
mul_mc  out  32  to pm32 mc; held stable from START until next grant
mul_mp  out  32  to pm32 mp
mul_p  in  64  from pm32 p
mul_done  in  1  from pm32 done (level, stays high until next start)

Behaviour:
- Reset (async, any state): state=IDLE; ptr=N-1; gnt, rsp_valid, rsp_err, mul_start, busy = 0; rsp_id, rsp_p, mul_mc, mul_mp, timer = 0.
- Reset mid-operation discards the operation; no response is produced. pm32 shares rst.
- States: IDLE, START, ARM, WAIT, RESP.
- IDLE:
  - If req != 0, select the winner: the first set bit searching (ptr+1) mod N upward with wrap.
  - Register that requester's mc/mp into mul_mc/mul_mp, assert gnt[winner] for this cycle, ptr <= winner, rsp_id <= winner, then go to START.
  - gnt is combinational from req in IDLE only; it is 0 in all other states.
- START: mul_start=1 for exactly this cycle, then go to ARM.
- ARM: one guard cycle. mul_done is ignored here because a stale DONE level from the previous op drops only after pm32 samples start. Clear timer, then go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If mul_done=1: rsp_p <= mul_p, rsp_err <= 0, go to RESP.
  - Else if timer == TIMEOUT-1: rsp_p <= 0, rsp_err <= 1, go to RESP.
  - If both conditions hold in the same cycle, done wins.
- RESP: rsp_valid=1 for this cycle. rsp_id, rsp_p and rsp_err are stable here and held until the next RESP. Then go to IDLE. There is no backpressure; requesters must accept the response.
- Latency: gnt at cycle G, mul_start at G+1, pm32 done at G+67, rsp_valid at G+68. Minimum issue interval is 69 cycles (one IDLE cycle between operations).
- Requester protocol:
  - Drop req in the cycle after seeing gnt, unless a further operation is wanted.
  - A req still high in the next IDLE is treated as a new request.
  - Changing operands while req=1 before gnt is legal; the values present in the gnt cycle are used.
- Fairness: the requester just granted has the lowest priority at the next arbitration. ptr does not change when nothing is granted.
- Arithmetic: signed two's-complement; no truncation or rounding in this block. The product is passed through unchanged.

Test Plan:
- Single op: req[0]=1, mc=7, mp=-3 -> gnt[0] pulse at G, mul_start at G+1, rsp_valid at G+68 with rsp_id=0, rsp_p=64'hFFFF_FFFF_FFFF_FFEB (-21), rsp_err=0.
- Contention: req=4'b1111 held continuously -> grants in order 0,1,2,3,0 at 69-cycle spacing; each rsp_id matches the granted index; operands (i+1)*1000 x -(i+2) produce matching products.
- Fairness after reset: only req[2] and req[3] set -> 2 granted first, then 3, then 2.
- Timeout: mul_done tied 0, TIMEOUT=100 -> rsp_valid at gnt+2+100+1 with rsp_err=1, rsp_p=0; arbiter then grants the next request.
- Stale done: pm32 left in DONE from a prior op (mul_done=1) -> new op does not complete early; rsp arrives at G+68 with the new product 0x7FFFFFFF*0x7FFFFFFF = 64'h3FFF_FFFF_0000_0001.
- Reset mid-op: assert rst 30 cycles after gnt -> all outputs 0 immediately, no rsp_valid. After release, a held req[1] is granted first (ptr=N-1 restarts the search at 0).

Source files
------------

// File: rtl/pm32_arbiter.sv
// rtl/pm32_arbiter.sv - round-robin arbiter and sequencer sharing one pm32 serial multiplier
module pm32_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] mc_in,
  input  logic [32*N-1:0] mp_in,
  output logic [N-1:0]    gnt,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [63:0]     rsp_p,
  output logic            rsp_err,
  output logic            busy,
  output logic            mul_start,
  output logic [31:0]     mul_mc,
  output logic [31:0]     mul_mp,
  input  logic [63:0]     mul_p,
  input  logic            mul_done
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, ARM, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [TW-1:0]  timer;
  logic           win_found;
  logic [IDW-1:0] win;
  logic [31:0]    mc_sel;
  logic [31:0]    mp_sel;
  logic           timeout_hit;

  // Rotating search: the requester after ptr has highest priority.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!win_found && ((req >> idx) & N'(1)) != '0) begin
        win_found = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  assign mc_sel      = 32'(mc_in >> (32 * win));
  assign mp_sel      = 32'(mp_in >> (32 * win));
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    gnt       = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rst so a held request cannot pulse gnt while in reset.
        if (win_found && !rst) begin
          gnt      = N'(1) << win;
          state_nx = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nx  = ARM;
      end
      ARM:  state_nx = WAIT;
      WAIT: begin
        if (mul_done || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IDW'(N - 1);
      rsp_id  <= '0;
      rsp_p   <= '0;
      rsp_err <= 1'b0;
      mul_mc  <= '0;
      mul_mp  <= '0;
      timer   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (win_found) begin
            ptr    <= win;
            rsp_id <= win;
            mul_mc <= mc_sel;
            mul_mp <= mp_sel;
          end
        end
        // A stale done level from the previous op is still visible here.
        ARM: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (mul_done) begin
            rsp_p   <= mul_p;
            rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            rsp_p   <= '0;
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm32_arbiter.sv
// tb/tb_pm32_arbiter.sv - table-driven scoreboard bench for pm32_arbiter
module tb_pm32_arbiter;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] mc_in;
  logic [32*N-1:0] mp_in;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [63:0]     rsp_p;
  logic            rsp_err;
  logic            busy;
  logic            mul_start;
  logic [31:0]     mul_mc;
  logic [31:0]     mul_mp;
  logic [63:0]     mul_p;
  logic            mul_done;

  always #5 clk = ~clk;

  pm32_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .mc_in(mc_in), .mp_in(mp_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start),
    .mul_mc(mul_mc), .mul_mp(mul_mp), .mul_p(mul_p), .mul_done(mul_done)
  );

  // pm32 behavioural model: done rises 66 cycles after start is sampled, stays high until next start
  logic        m_done, m_run, kill;
  logic [6:0]  m_cnt;
  logic [31:0] m_mc, m_mp;
  logic signed [63:0] m_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0; m_run <= 1'b0; m_cnt <= '0; m_p <= '0; m_mc <= '0; m_mp <= '0;
    end else if (mul_start) begin
      m_done <= 1'b0; m_run <= 1'b1; m_cnt <= 7'd1; m_mc <= mul_mc; m_mp <= mul_mp;
    end else if (m_run) begin
      if (m_cnt == 7'd65) begin
        m_done <= 1'b1;
        m_run  <= 1'b0;
        m_p    <= $signed(m_mc) * $signed(m_mp);
      end else begin
        m_cnt <= m_cnt + 7'd1;
      end
    end
  end

  assign mul_p    = m_p;
  assign mul_done = m_done & ~kill;

  int cyc  = 0;
  int nrsp = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid) nrsp <= nrsp + 1;
  end

  typedef struct {
    bit           rb;
    logic [N-1:0] req;
    logic [N-1:0] ra;
    bit           kill;
    logic [127:0] mc;
    logic [127:0] mp;
    int           id;
    logic [63:0]  p;
    bit           err;
    int           lat;
    int           gap;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] p;
    bit          err;
    int          lat;
  } exp_t;

  vec_t tv[15];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_g = 0;

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    kill = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (gnt != '0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int gcyc, input string t);
    exp_t e;
    bit   seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk({t, "_rsp_seen"}, 64'(seen), 64'd1);
    chk({t, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      chk({t, "_rsp_id"}, 64'(rsp_id), 64'(e.id));
      chk({t, "_rsp_p"}, rsp_p, e.p);
      chk({t, "_rsp_err"}, 64'(rsp_err), 64'(e.err));
      chk({t, "_latency"}, 64'(cyc - gcyc), 64'(e.lat));
      @(negedge clk);
      #1;
      chk({t, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
      chk({t, "_idle"}, 64'(busy), 64'd0);
      chk({t, "_rsp_held"}, rsp_p, e.p);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t  v = tv[i];
    bit    ok;
    int    gcyc;
    string t = $sformatf("v%0d", i);
    if (v.rb) do_reset();
    req   = v.req;
    mc_in = v.mc;
    mp_in = v.mp;
    kill  = v.kill;
    sb.push_back('{v.id, v.p, v.err, v.lat});
    wait_gnt(ok);
    chk({t, "_gnt_seen"}, 64'(ok), 64'd1);
    if (!ok) begin
      sb.delete(sb.size() - 1);
      req = '0;
      return;
    end
    gcyc = cyc;
    chk({t, "_gnt"}, 64'(gnt), 64'(N'(1) << v.id));
    if (v.gap != 0) chk({t, "_gap"}, 64'(gcyc - last_g), 64'(v.gap));
    last_g = gcyc;
    @(negedge clk);
    #1;
    chk({t, "_start"}, 64'(mul_start), 64'd1);
    chk({t, "_gnt_off"}, 64'(gnt), 64'd0);
    chk({t, "_busy"}, 64'(busy), 64'd1);
    chk({t, "_mul_mc"}, 64'(mul_mc), 64'(v.mc[32*v.id +: 32]));
    chk({t, "_mul_mp"}, 64'(mul_mp), 64'(v.mp[32*v.id +: 32]));
    req = v.ra;
    wait_rsp(gcyc, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nrsp0;

    tv[0]  = '{0, 4'b0001, 4'b0000, 0, pk(32'd7, 0, 0, 0), pk(32'hFFFF_FFFD, 0, 0, 0), 0, 64'hFFFF_FFFF_FFFF_FFEB, 0, 68, 0};
    tv[1]  = '{0, 4'b0010, 4'b0000, 0, pk(0, 32'h7FFF_FFFF, 0, 0), pk(0, 32'h7FFF_FFFF, 0, 0), 1, 64'h3FFF_FFFF_0000_0001, 0, 68, 0};
    tv[2]  = '{0, 4'b0100, 4'b0000, 1, pk(0, 0, 32'd5, 0), pk(0, 0, 32'd6, 0), 2, 64'd0, 1, 103, 0};
    tv[3]  = '{0, 4'b1000, 4'b0000, 0, pk(0, 0, 0, 32'hFFFF_FFFB), pk(0, 0, 0, 32'hFFFF_FFFA), 3, 64'd30, 0, 68, 0};
    tv[4]  = '{0, 4'b0101, 4'b0000, 0, pk(32'h8000_0000, 0, 32'd9, 0), pk(32'h8000_0000, 0, 32'd9, 0), 0, 64'h4000_0000_0000_0000, 0, 68, 0};
    tv[5]  = '{0, 4'b0101, 4'b0000, 0, pk(32'd1, 0, 32'h8000_0000, 0), pk(32'd1, 0, 32'h7FFF_FFFF, 0), 2, 64'hC000_0000_8000_0000, 0, 68, 0};
    for (int i = 0; i < 5; i++) begin
      tv[6+i] = '{(i == 0), 4'b1111, (i == 4) ? 4'b0000 : 4'b1111, 0,
                  pk(32'd1000, 32'd2000, 32'd3000, 32'd4000),
                  pk(32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFB),
                  i % 4, 64'(-64'sd1000 * 64'(((i % 4) + 1) * ((i % 4) + 2))), 0, 68, (i == 0) ? 0 : 69};
    end
    tv[11] = '{1, 4'b1100, 4'b1100, 0, pk(0, 0, 32'd100, 32'd200), pk(0, 0, 32'd3, 32'hFFFF_FFFF), 2, 64'd300, 0, 68, 0};
    tv[12] = '{0, 4'b1100, 4'b1100, 0, pk(0, 0, 32'd100, 32'd200), pk(0, 0, 32'd3, 32'hFFFF_FFFF), 3, -64'sd200, 0, 68, 69};
    tv[13] = '{0, 4'b1100, 4'b0000, 0, pk(0, 0, 32'd100, 32'd200), pk(0, 0, 32'd3, 32'hFFFF_FFFF), 2, 64'd300, 0, 68, 69};
    tv[14] = '{0, 4'b0010, 4'b0000, 0, pk(0, 32'd11, 0, 0), pk(0, 32'd13, 0, 0), 1, 64'd143, 0, 68, 0};

    rst   = 1'b1;
    req   = 4'b0001;
    mc_in = '0;
    mp_in = '0;
    kill  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, gnt, rsp_valid, rsp_err, mul_start}), 64'd0);
    chk("reset_rsp", 64'({rsp_id, rsp_p[61:0]}), 64'd0);
    chk("reset_operands", 64'({mul_mc, mul_mp}), 64'd0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    do_reset();
    req   = 4'b0010;
    mc_in = tv[14].mc;
    mp_in = tv[14].mp;
    sb.push_back('{1, 64'd143, 0, 68});
    nrsp0 = nrsp;
    wait_gnt(ok);
    chk("mid_gnt", 64'(gnt), 64'b0010);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({busy, gnt, rsp_valid, rsp_err, mul_start}), 64'd0);
    chk("mid_rst_id", 64'(rsp_id), 64'd0);
    chk("mid_rst_operands", 64'({mul_mc, mul_mp}), 64'd0);
    chk("mid_rst_p", rsp_p, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_vec(14);
    chk("mid_rsp_count", 64'(nrsp - nrsp0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
